hilo_mult_ctrl: RTL and testbench

Sequencer and owner of the HI/LO register pair for the five-stage MIPS core. Runs a 32-iteration shift-add multiply for MULT/MULTU issued from EX. Arbitrates HI/LO writes between the multiplier and MTHI/MTLO retiring in WB. Stalls the front of the pipeline when a new multiply or an MFHI/MFLO meets a busy unit.

---
 rtl/hilo_mult_ctrl.sv | 139 +++++++++++++
 tb/tb_hilo_mult_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_ctrl.sv
// ============================================================================
// Module   : hilo_mult_ctrl
// Purpose  : HI/LO owner and 32-iteration shift-add MULT/MULTU sequencer.
//            Optional HILO_FWD_EN forwards MTHI/MTLO data onto hi/lo.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hilo_mult_ctrl #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi_wb,
  input  logic        mtlo_wb,
  input  logic [31:0] wdata_wb,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_acc;
  logic [31:0]      r_mag_a;
  logic [31:0]      r_mag_b;
  logic             r_neg;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_done;

  logic             w_abort;
  logic [32:0]      w_sum;
  logic [63:0]      w_acc_step;
  logic [63:0]      w_product;
  logic [31:0]      w_abs_a;
  logic [31:0]      w_abs_b;

  assign busy    = (r_state != IDLE);
  assign stall   = busy & (start | mfhi_req | mflo_req);
  assign done    = r_done;
  // A younger MTHI/MTLO retiring while the unit is busy kills the multiply.
  assign w_abort = busy & (mthi_wb | mtlo_wb);

  // Two's-complement negate leaves 0x80000000 unchanged, which is its magnitude.
  assign w_abs_a = (signed_op & op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign w_abs_b = (signed_op & op_b[31]) ? (~op_b + 32'd1) : op_b;

  assign w_sum      = {1'b0, r_acc[63:32]} + (r_mag_b[0] ? {1'b0, r_mag_a} : 33'd0);
  assign w_acc_step = {w_sum, r_acc[31:1]};
  assign w_product  = r_neg ? (~r_acc + 64'd1) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_count == LAST_CNT) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_acc   <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == FIX) && !w_abort;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mag_a <= w_abs_a;
            r_mag_b <= w_abs_b;
            r_neg   <= signed_op & (op_a[31] ^ op_b[31]);
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_step;
          r_mag_b <= {1'b0, r_mag_b[31:1]};
          r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
      if ((r_state == FIX) && !w_abort) begin
        r_hi <= w_product[63:32];
        r_lo <= w_product[31:0];
      end
      // WB writes come last so they override a product landing on the same edge.
      if (mthi_wb) r_hi <= wdata_wb;
      if (mtlo_wb) r_lo <= wdata_wb;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = mthi_wb ? wdata_wb : r_hi;
  assign lo = mtlo_wb ? wdata_wb : r_lo;
`else
  assign hi = r_hi;
  assign lo = r_lo;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_mult_ctrl.sv
// ============================================================================
// Module   : tb_hilo_mult_ctrl
// Purpose  : Directed self-checking bench for hilo_mult_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi_wb;
  logic        mtlo_wb;
  logic [31:0] wdata_wb;
  logic        mfhi_req;
  logic        mflo_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int total = 0;
  int bad   = 0;

  hilo_mult_ctrl #(.ITERS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .mthi_wb   (mthi_wb),
    .mtlo_wb   (mtlo_wb),
    .wdata_wb  (wdata_wb),
    .mfhi_req  (mfhi_req),
    .mflo_req  (mflo_req),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen; n is edges counted after the acceptance edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_mult(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int n;
    start = 1'b1; signed_op = sg; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    check_val({tag, "_lat"}, 64'(n), 64'd33);
    check_val({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    mthi_wb = 1'b0; mtlo_wb = 1'b0; wdata_wb = '0; mfhi_req = 1'b0; mflo_req = 1'b0;
    tick();
    tick();
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_stall", 64'(stall), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    do_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_mult("mult_min", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_mult("mult_neg", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_mult("multu_sh", 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);

    // Stall: MFHI from the cycle ending E5, second start held from the cycle ending E10.
    start = 1'b1; signed_op = 1'b0; op_a = 32'd3; op_b = 32'd4;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    mfhi_req = 1'b1;
    #1;
    check_val("stall_mfhi_first", 64'(stall), 64'd1);
    for (int e = 5; e <= 32; e++) begin
      tick();
      check_val("stall_run", 64'(stall), 64'd1);
      if (e == 9) begin
        start = 1'b1; op_a = 32'd6; op_b = 32'd7;
      end
    end
    tick();
    check_val("stall_done", 64'(done), 64'd1);
    check_val("stall_released", 64'(stall), 64'd0);
    check_val("stall_idle", 64'(busy), 64'd0);
    check_val("stall_lo1", 64'(lo), 64'd12);
    mfhi_req = 1'b0;
    tick();
    start = 1'b0;
    check_val("b2b_accepted", 64'(busy), 64'd1);
    wait_done(n);
    check_val("b2b_lat", 64'(n), 64'd33);
    check_val("b2b_hi", 64'(hi), 64'd0);
    check_val("b2b_lo", 64'(lo), 64'd42);
    tick();

    // MTHI during RUN aborts the multiply.
    start = 1'b1; op_a = 32'd2; op_b = 32'd3;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    mthi_wb = 1'b1; wdata_wb = 32'h1234_5678;
    tick();
    mthi_wb = 1'b0;
    check_val("abort_hi", 64'(hi), 64'h1234_5678);
    check_val("abort_lo", 64'(lo), 64'd42);
    check_val("abort_idle", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_val("abort_no_done", 64'(done_seen), 64'd0);
    check_val("abort_hi_kept", 64'(hi), 64'h1234_5678);

    // MTLO coinciding with the FIX edge wins and suppresses done.
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 32; e++) tick();
    mtlo_wb = 1'b1; wdata_wb = 32'hA5A5_A5A5;
    tick();
    mtlo_wb = 1'b0;
    check_val("fixwb_lo", 64'(lo), 64'hA5A5_A5A5);
    check_val("fixwb_hi", 64'(hi), 64'h1234_5678);
    check_val("fixwb_no_done", 64'(done), 64'd0);
    check_val("fixwb_idle", 64'(busy), 64'd0);

    // MTLO in IDLE: same-cycle visibility only with forwarding.
    mtlo_wb = 1'b1; wdata_wb = 32'hCAFE_F00D;
    #1;
`ifdef HILO_FWD_EN
    check_val("fwd_lo_same", 64'(lo), 64'hCAFE_F00D);
`else
    check_val("fwd_lo_same", 64'(lo), 64'hA5A5_A5A5);
`endif
    tick();
    mtlo_wb = 1'b0;
    check_val("fwd_lo_after", 64'(lo), 64'hCAFE_F00D);

    // MTHI together with start in IDLE: WB lands, multiply still runs.
    mthi_wb = 1'b1; wdata_wb = 32'hDEAD_BEEF;
    start = 1'b1; signed_op = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    tick();
    mthi_wb = 1'b0; start = 1'b0;
    check_val("idlewb_hi", 64'(hi), 64'hDEAD_BEEF);
    check_val("idlewb_busy", 64'(busy), 64'd1);
    wait_done(n);
    check_val("idlewb_lat", 64'(n), 64'd33);
    check_val("idlewb_prod", {hi, lo}, 64'd1);
    tick();

    // Reset mid-multiply.
    start = 1'b1; signed_op = 1'b0; op_a = 32'd5; op_b = 32'd5;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_hilo", {hi, lo}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_val("midrst_no_done", 64'(done_seen), 64'd0);
    check_val("midrst_hilo_kept", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
